// File: rtl/hdmi_mode_sequencer_if.sv
// Mode-sequencer signal bundle between the VDP side and hdmi_output.
// master = sequencer, slave = environment driving requests and beam position.
interface hdmi_mode_sequencer_if;
  logic       req_pal;
  logic       audio_en;
  logic [9:0] cx;
  logic [9:0] cy;
  logic       hdmi_reset;
  logic       mode_pal;
  logic       include_audio;
  logic       video_blank;
  logic       busy;

  modport master (
    input  req_pal, audio_en, cx, cy,
    output hdmi_reset, mode_pal, include_audio,
    output video_blank, busy
  );

  modport slave (
    output req_pal, audio_en, cx, cy,
    input  hdmi_reset, mode_pal, include_audio,
    input  video_blank, busy
  );
endinterface

// File: rtl/hdmi_mode_sequencer.sv
// 50/60 Hz mode-change sequencer for hdmi_output.
// Debounce, mute/blank, frame-aligned reset pulse, settle, watchdog.
module hdmi_mode_sequencer #(
  parameter int unsigned STABLE_FRAMES  = 2,
  parameter int unsigned MUTE_FRAMES    = 1,
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter bit          DEFAULT_PAL    = 1'b0
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  hdmi_mode_sequencer_if.master bus
);

  localparam int unsigned FRM_MAX =
    (MUTE_FRAMES > SETTLE_FRAMES) ? MUTE_FRAMES
                                  : SETTLE_FRAMES;
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int FW = $clog2(FRM_MAX + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MUTE,
    S_RESET,
    S_SETTLE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_pal_q, mode_pal_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          origin_q, sof_q;
  logic          hdmi_reset_q, hdmi_reset_d;
  logic          include_audio_q, include_audio_d;
  logic          video_blank_q, video_blank_d;
  logic          busy_q, busy_d;

  logic          origin;
  logic          mismatch;
  logic [SW-1:0] stable_inc;
  logic [FW-1:0] frame_inc;
  logic [RW-1:0] rcnt_inc;
  logic [WW-1:0] wdog_inc;
  logic          wdog_hit;

  assign origin   = (bus.cx == '0) && (bus.cy == '0);
  assign mismatch = bus.req_pal != mode_pal_q;

  // Saturating increments for every counter
  always_comb begin
    stable_inc = (stable_q == SW'(STABLE_FRAMES))
               ? stable_q : stable_q + SW'(1);
    frame_inc  = (frame_q == FW'(FRM_MAX))
               ? frame_q : frame_q + FW'(1);
    rcnt_inc   = (rcnt_q == RW'(RESET_CYCLES))
               ? rcnt_q : rcnt_q + RW'(1);
    wdog_inc   = (wdog_q == WW'(TIMEOUT_CYCLES))
               ? wdog_q : wdog_q + WW'(1);
    wdog_hit   = wdog_inc == WW'(TIMEOUT_CYCLES);
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    mode_pal_d = mode_pal_q;
    stable_d   = stable_q;
    frame_d    = frame_q;
    rcnt_d     = rcnt_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      S_RUN: begin
        if (sof_q) begin
          if (!mismatch) begin
            stable_d = '0;
          end else if (stable_inc == SW'(STABLE_FRAMES)) begin
            state_d  = S_MUTE;
            stable_d = '0;
            frame_d  = '0;
            wdog_d   = '0;
          end else begin
            stable_d = stable_inc;
          end
        end
      end
      S_MUTE: begin
        if (!mismatch) begin
          state_d  = S_RUN;
          stable_d = '0;
        end else if (sof_q) begin
          wdog_d = '0;
          if (frame_inc == FW'(MUTE_FRAMES)) begin
            state_d    = S_RESET;
            mode_pal_d = bus.req_pal;
            rcnt_d     = '0;
          end else begin
            frame_d = frame_inc;
          end
        end else if (wdog_hit) begin
          state_d    = S_RESET;
          mode_pal_d = bus.req_pal;
          rcnt_d     = '0;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      S_RESET: begin
        if (rcnt_inc == RW'(RESET_CYCLES)) begin
          state_d = S_SETTLE;
          rcnt_d  = '0;
          frame_d = '0;
          wdog_d  = '0;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      S_SETTLE: begin
        if (sof_q) begin
          wdog_d = '0;
          if (frame_inc == FW'(SETTLE_FRAMES)) begin
            state_d  = S_RUN;
            stable_d = '0;
          end else begin
            frame_d = frame_inc;
          end
        end else if (wdog_hit) begin
          state_d    = S_RESET;
          mode_pal_d = bus.req_pal;
          rcnt_d     = '0;
        end else begin
          wdog_d = wdog_inc;
        end
      end
    endcase
    hdmi_reset_d    = state_q == S_RESET;
    include_audio_d = (state_q == S_RUN) && bus.audio_en;
    video_blank_d   = state_q != S_RUN;
    busy_d          = state_q != S_RUN;
  end

  // State, counters, frame-start detect and registered outputs
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_RESET;
      mode_pal_q      <= DEFAULT_PAL;
      stable_q        <= '0;
      frame_q         <= '0;
      rcnt_q          <= '0;
      wdog_q          <= '0;
      origin_q        <= 1'b0;
      sof_q           <= 1'b0;
      hdmi_reset_q    <= 1'b1;
      include_audio_q <= 1'b0;
      video_blank_q   <= 1'b1;
      busy_q          <= 1'b1;
    end else begin
      state_q         <= state_d;
      mode_pal_q      <= mode_pal_d;
      stable_q        <= stable_d;
      frame_q         <= frame_d;
      rcnt_q          <= rcnt_d;
      wdog_q          <= wdog_d;
      origin_q        <= origin;
      sof_q           <= origin && !origin_q;
      hdmi_reset_q    <= hdmi_reset_d;
      include_audio_q <= include_audio_d;
      video_blank_q   <= video_blank_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.hdmi_reset    = hdmi_reset_q;
  assign bus.mode_pal      = mode_pal_q;
  assign bus.include_audio = include_audio_q;
  assign bus.video_blank   = video_blank_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Bench for hdmi_mode_sequencer: small raster, event-level
// expectations (pulse lengths, frame starts between events).
module tb_hdmi_mode_sequencer;

  localparam int W  = 20;
  localparam int H  = 8;
  localparam int F  = W * H;
  localparam int TO = 600;

  logic clk;
  logic reset_n;
  hdmi_mode_sequencer_if bus();

  hdmi_mode_sequencer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_pixel(clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   fx = 0;
  int   fy = 0;
  bit   freeze = 0;
  bit   org_prev = 1;
  int   n_org = 0;
  int   n_hr_rise = 0;
  int   busy_hi = 0;
  logic hr_prev = 1'b1;
  bit   mode_model = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // one cycle: sample outputs at negedge, then drive raster
  task automatic tick();
    @(negedge clk);
    if (bus.hdmi_reset === 1'b1 && hr_prev !== 1'b1)
      n_hr_rise++;
    hr_prev = bus.hdmi_reset;
    if (bus.busy === 1'b1) busy_hi++;
    if (!freeze) begin
      fx++;
      if (fx == W) begin
        fx = 0;
        fy++;
        if (fy == H) fy = 0;
      end
      bus.cx = 10'(fx);
      bus.cy = 10'(fy);
    end else begin
      bus.cx = 10'd5;
      bus.cy = 10'd5;
    end
    if (bus.cx == 0 && bus.cy == 0 && !org_prev) n_org++;
    org_prev = (bus.cx == 0 && bus.cy == 0);
  endtask

  function automatic logic pick(input int sel);
    return (sel == 0) ? bus.hdmi_reset : bus.busy;
  endfunction

  task automatic wait_sig(input int sel, input logic v,
                          input int bound, input string tag,
                          output int n);
    n = 0;
    while (pick(sel) !== v && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(pick(sel)), 32'(v));
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (bus.hdmi_reset === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  // move to a point a little after a frame start
  task automatic align();
    int o;
    int g;
    o = n_org;
    g = 0;
    while (n_org == o && g < 2 * F) begin
      tick();
      g++;
    end
    repeat (10) tick();
  endtask

  initial begin
    int n;
    int o;
    int hr0;
    int b0;
    int kind;
    bit r;
    bit a;

    reset_n = 1'b0;
    bus.req_pal = 1'b0;
    bus.audio_en = 1'b1;
    bus.cx = '0;
    bus.cy = '0;

    // power-up
    repeat (5) tick();
    chk("rst_hdmi_reset", 32'(bus.hdmi_reset), 1);
    chk("rst_mode_pal", 32'(bus.mode_pal), 0);
    chk("rst_include_audio", 32'(bus.include_audio), 0);
    chk("rst_video_blank", 32'(bus.video_blank), 1);
    chk("rst_busy", 32'(bus.busy), 1);
    reset_n = 1'b1;
    tick();
    count_high(n);
    chk("pwr_hr_len", n, 16);
    o = n_org;
    wait_sig(1, 1'b0, 4 * F, "pwr_busy_low", n);
    chk("pwr_settle_sofs", n_org - o, 2);
    tick();
    tick();
    chk("pwr_audio", 32'(bus.include_audio), 1);
    chk("pwr_blank", 32'(bus.video_blank), 0);
    chk("pwr_mode", 32'(bus.mode_pal), 0);

    // mode switch 0 -> 1
    align();
    a = 1'($urandom_range(0, 1));
    bus.audio_en = a;
    o = n_org;
    bus.req_pal = 1'b1;
    wait_sig(1, 1'b1, 4 * F, "sw_busy_high", n);
    chk("sw_stable_sofs", n_org - o, 2);
    chk("sw_mute_audio", 32'(bus.include_audio), 0);
    chk("sw_mute_blank", 32'(bus.video_blank), 1);
    chk("sw_mute_hr", 32'(bus.hdmi_reset), 0);
    o = n_org;
    wait_sig(0, 1'b1, 2 * F, "sw_hr_high", n);
    chk("sw_mute_sofs", n_org - o, 1);
    chk("sw_mode", 32'(bus.mode_pal), 1);
    count_high(n);
    chk("sw_hr_len", n, 16);
    o = n_org;
    wait_sig(1, 1'b0, 4 * F, "sw_busy_low", n);
    chk("sw_settle_sofs", n_org - o, 2);
    tick();
    tick();
    chk("sw_audio", 32'(bus.include_audio), 32'(a));
    mode_model = 1;

    // glitch: mismatch for a single frame start
    align();
    hr0 = n_hr_rise;
    b0 = busy_hi;
    bus.req_pal = 1'b0;
    o = n_org;
    n = 0;
    while (n_org == o && n < 2 * F) begin
      tick();
      n++;
    end
    repeat ($urandom_range(5, 120)) tick();
    bus.req_pal = 1'b1;
    repeat (3 * F) tick();
    chk("gl_busy_cycles", busy_hi - b0, 0);
    chk("gl_resets", n_hr_rise - hr0, 0);
    chk("gl_mode", 32'(bus.mode_pal), 1);

    // abort during mute
    align();
    hr0 = n_hr_rise;
    bus.req_pal = 1'b0;
    wait_sig(1, 1'b1, 4 * F, "ab_busy_high", n);
    bus.req_pal = 1'b1;
    wait_sig(1, 1'b0, 4, "ab_busy_low", n);
    repeat (3 * F) tick();
    chk("ab_resets", n_hr_rise - hr0, 0);
    chk("ab_mode", 32'(bus.mode_pal), 1);
    chk("ab_audio", 32'(bus.include_audio), 32'(a));

    // watchdog in settle, request changes meanwhile
    align();
    bus.req_pal = 1'b0;
    wait_sig(0, 1'b1, 5 * F, "wd_first_hr", n);
    count_high(n);
    chk("wd_first_len", n, 16);
    freeze = 1;
    bus.req_pal = 1'b1;
    wait_sig(0, 1'b1, TO + 50, "wd_hr_high", n);
    chk("wd_time", 32'(n >= TO - 2 && n <= TO + 2), 1);
    chk("wd_relatch_mode", 32'(bus.mode_pal), 1);
    count_high(n);
    chk("wd_hr_len", n, 16);
    freeze = 0;
    fx = 5;
    fy = 5;
    o = n_org;
    wait_sig(1, 1'b0, 4 * F, "wd_busy_low", n);
    chk("wd_settle_sofs", n_org - o, 2);
    chk("wd_mode", 32'(bus.mode_pal), 1);
    mode_model = 1;

    // randomized requests against the mode model
    for (int i = 0; i < 6; i++) begin
      align();
      kind = $urandom_range(0, 2);
      a = 1'($urandom_range(0, 1));
      bus.audio_en = a;
      hr0 = n_hr_rise;
      if (kind < 2) begin
        r = 1'($urandom_range(0, 1));
        bus.req_pal = r;
        repeat (7 * F) tick();
        chk("rnd_mode", 32'(bus.mode_pal), 32'(r));
        chk("rnd_resets", n_hr_rise - hr0,
            32'(r != mode_model));
        mode_model = r;
      end else begin
        bus.req_pal = !mode_model;
        o = n_org;
        n = 0;
        while (n_org == o && n < 2 * F) begin
          tick();
          n++;
        end
        repeat ($urandom_range(5, 120)) tick();
        bus.req_pal = mode_model;
        repeat (3 * F) tick();
        chk("rnd_glitch_resets", n_hr_rise - hr0, 0);
        chk("rnd_glitch_mode", 32'(bus.mode_pal),
            32'(mode_model));
      end
      chk("rnd_busy", 32'(bus.busy), 0);
      chk("rnd_audio", 32'(bus.include_audio), 32'(a));
    end

    // reset_n during RESET with mode_pal=1
    if (mode_model) begin
      align();
      bus.req_pal = 1'b0;
      repeat (7 * F) tick();
      chk("mid_pre_mode", 32'(bus.mode_pal), 0);
    end
    align();
    bus.req_pal = 1'b1;
    wait_sig(0, 1'b1, 5 * F, "mid_hr_high", n);
    repeat (3) tick();
    chk("mid_mode_before", 32'(bus.mode_pal), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_mode", 32'(bus.mode_pal), 0);
    chk("mid_hr", 32'(bus.hdmi_reset), 1);
    chk("mid_busy", 32'(bus.busy), 1);
    chk("mid_audio", 32'(bus.include_audio), 0);
    chk("mid_blank", 32'(bus.video_blank), 1);
    bus.req_pal = 1'b0;
    repeat (5) tick();
    reset_n = 1'b1;
    tick();
    count_high(n);
    chk("mid_hr_len", n, 16);
    o = n_org;
    wait_sig(1, 1'b0, 4 * F, "mid_busy_low", n);
    chk("mid_settle_sofs", n_org - o, 2);
    chk("mid_final_mode", 32'(bus.mode_pal), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
